id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Registered, parametrised RV32I decode stage between IF and the ID/EX path.
//  Classifies each instruction and builds its immediate, fetches rs1/rs2 from regfile.
//  Forwards results from EX and MEM, and stalls on load-use hazards.
//  Decoupled from IF and EX by valid/ready handshakes through a 2-entry output skid buffer.
// PARAMETERS
//  XLEN     32  data/address width
//  REG_AW   5   register address width
//  FWD_EN   1   1: EX/MEM forwarding on; 0: regfile data only, stall on any EX/MEM RAW
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous, active-low reset (0 = reset)
//  flush        in   1       synchronous flush (branch redirect)
//  in_valid     in   1       IF presents pc_i/inst_i
//  in_ready     out  1       stage accepts this cycle
//  pc_i         in   XLEN    instruction address
//  inst_i       in   32      instruction word
//  reg1_read_o  out  1       rs1 read enable to regfile (combinational)
//  reg1_addr_o  out  REG_AW  rs1 = inst_i[19:15]
//  reg1_data_i  in   XLEN    regfile rs1 data, same cycle
//  reg2_read_o  out  1       rs2 read enable to regfile (combinational)
//  reg2_addr_o  out  REG_AW  rs2 = inst_i[24:20]
//  reg2_data_i  in   XLEN    regfile rs2 data, same cycle
//  ex_wreg/ex_wd/ex_wdata/ex_is_load   in  1/REG_AW/XLEN/1  EX-stage writeback info
//  mem_wreg/mem_wd/mem_wdata           in  1/REG_AW/XLEN    MEM-stage writeback info
//  out_valid    out  1       head entry valid
//  out_ready    in   1       downstream consumes head entry
//  pc_o         out  XLEN    registered outputs of head entry:
//  aluop_o[6:0], alufunct3_o[2:0], alufunct7_o[6:0], reg1_o, reg2_o, imm_o (XLEN),
//  wd_o (REG_AW), wreg_o (1), illegal_o (1)
// BEHAVIOUR
//  Decode (comb.): R=0110011, I=0010011/0000011/1100111, S=0100011, B=1100011,
//   U=0110111/0010111, J=1101111. Any other opcode -> illegal: wreg=0, reads off, imm=0.
//  Immediates are sign-extended to XLEN. Formats: I, S, B (bit0=0), U (low 12 bits=0), J (bit0=0).
//  Read enables: R/S/B read rs1 and rs2; I reads rs1; U/J read none.
//  Source select per operand, highest priority first:
//   1. addr==0 -> 0.
//   2. ex_wreg && ex_wd==addr && !ex_is_load -> ex_wdata.
//   3. mem_wreg && mem_wd==addr -> mem_wdata.
//   4. Otherwise the regfile data.
//  reg1_o: rs1 value when rs1 is read. AUIPC/JAL: pc_i. LUI/illegal: 0.
//  reg2_o: rs2 value when rs2 is read, otherwise imm.
//  wreg: 1 for R/I/U/J types, but forced to 0 when rd==0. wd_o = inst_i[11:7].
//  Hazard (comb.), raised when in_valid and any of:
//   - a read source matches ex_wd (nonzero) with ex_wreg && ex_is_load;
//   - FWD_EN=0 and a read source matches an EX or MEM write (nonzero).
//  in_ready = (state != TWO) && !hazard && !flush. Capture = in_valid && in_ready.
//  Buffer FSM, states EMPTY / ONE / TWO (head register + skid register):
//   - EMPTY: on capture, load head -> ONE.
//   - ONE: consume only -> EMPTY. Capture+consume -> head<=new, stay ONE.
//     Capture only -> load skid, go to TWO.
//   - TWO: on consume, head<=skid -> ONE. in_ready=0, so no capture.
//   - consume = out_valid && out_ready.
//  Latency: accepted instruction appears on outputs the next cycle (1 cycle) when buffer drains.
//  Head/skid contents hold stable while out_valid && !out_ready.
//  flush: state->EMPTY next edge. Input in the flush cycle is dropped. Overrides all.
//  Reset (rst=0, async): state EMPTY, out_valid=0, all data outputs 0.
//   wreg_o=0, illegal_o=0, aluop_o=0; reset mid-transfer discards all entries.
//  Regfile read ports are 0/disabled when !in_valid.
// TESTING
//  1. Reset, then addi x1,x0,5 (0x00500093) at pc 0x100, out_ready=1.
//     -> next cycle: out_valid=1, reg1_o=0, reg2_o=imm_o=5, wd_o=1, wreg_o=1.
//  2. add x3,x1,x2 with ex_wreg=1, ex_wd=1, ex_wdata=7 and mem_wd=2, mem_wdata=9.
//     -> reg1_o=7, reg2_o=9 (regfile data ignored).
//  3. ex_is_load=1, ex_wd=1, instruction reads x1.
//     -> in_ready=0, no capture. Load drops next cycle -> captured with regfile data.
//  4. out_ready=0 for 3 cycles with in_valid=1.
//     -> 2 entries accepted, in_ready=0. Then out_ready=1 -> both emerge in order, no loss or dup.
//  5. flush asserted while state TWO with in_valid=1.
//     -> next cycle out_valid=0, in_ready=1; nothing emitted.
//  6. inst 0xFFFFFFFF -> illegal_o=1, wreg_o=0. rst=0 mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Registered RV32I decode stage that sits between instruction fetch and the
// ID/EX path. It does the following for each instruction:
//   - classifies the opcode and builds the sign-extended immediate;
//   - reads rs1/rs2 from the register file;
//   - forwards results from the EX and MEM stages;
//   - stalls on load-use hazards.
// Decoded instructions are held in a two-entry output buffer (head + skid).
// Because of the skid register, in_ready is never a combinational function
// of out_ready.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   flush                     synchronous pipeline flush (branch redirect)
//   in_valid/in_ready         upstream handshake for pc_i/inst_i
//   reg1_*/reg2_*             register file read ports (combinational)
//   ex_*, mem_*               writeback info used for forwarding and hazards
//   out_valid/out_ready       downstream handshake for the head entry
//   pc_o .. illegal_o         registered fields of the head entry
// ---------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    output logic              reg1_read_o,
    output logic [REG_AW-1:0] reg1_addr_o,
    input  logic [XLEN-1:0]   reg1_data_i,
    output logic              reg2_read_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    input  logic [XLEN-1:0]   reg2_data_i,
    input  logic              ex_wreg,
    input  logic [REG_AW-1:0] ex_wd,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pc_o,
    output logic [6:0]        aluop_o,
    output logic [2:0]        alufunct3_o,
    output logic [6:0]        alufunct7_o,
    output logic [XLEN-1:0]   reg1_o,
    output logic [XLEN-1:0]   reg2_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic              illegal_o
);

    localparam logic       FWD_ON    = (FWD_EN != 0);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [6:0]        aluop;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [XLEN-1:0]   reg1;
        logic [XLEN-1:0]   reg2;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] wd;
        logic              wreg;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    entry_t            head;
    entry_t            skid;
    entry_t            dec;
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              is_r, is_i, is_s, is_b, is_u, is_j;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic              hazard;
    logic              capture;
    logic              consume;

    assign opcode = inst_i[6:0];
    assign rs1    = REG_AW'(inst_i[19:15]);
    assign rs2    = REG_AW'(inst_i[24:20]);
    assign rd     = REG_AW'(inst_i[11:7]);

    assign is_r = (opcode == OP_R);
    assign is_i = (opcode == OP_IMM) || (opcode == OP_LOAD) || (opcode == OP_JALR);
    assign is_s = (opcode == OP_STORE);
    assign is_b = (opcode == OP_BRANCH);
    assign is_u = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign is_j = (opcode == OP_JAL);

    // Regfile ports are only exercised for a presented instruction whose
    // format actually uses the operand.
    assign reg1_read_o = in_valid && (is_r || is_i || is_s || is_b);
    assign reg2_read_o = in_valid && (is_r || is_s || is_b);
    assign reg1_addr_o = in_valid ? rs1 : '0;
    assign reg2_addr_o = in_valid ? rs2 : '0;

    // 32-bit immediate per format; unrecognised opcodes and R-type give 0.
    always_comb begin
        imm32 = '0;
        if (is_i)
            imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        else if (is_s)
            imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        else if (is_b)
            imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        else if (is_u)
            imm32 = {inst_i[31:12], 12'b0};
        else if (is_j)
            imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    end

    // Operand source selection. x0 always reads 0. EX beats MEM because it
    // is the younger result. A load in EX has no data yet, so it is never
    // forwarded; that case is covered by the stall below.
    always_comb begin
        src1 = reg1_data_i;
        if (rs1 == '0)
            src1 = '0;
        else if (FWD_ON && ex_wreg && (ex_wd == rs1) && !ex_is_load)
            src1 = ex_wdata;
        else if (FWD_ON && mem_wreg && (mem_wd == rs1))
            src1 = mem_wdata;

        src2 = reg2_data_i;
        if (rs2 == '0)
            src2 = '0;
        else if (FWD_ON && ex_wreg && (ex_wd == rs2) && !ex_is_load)
            src2 = ex_wdata;
        else if (FWD_ON && mem_wreg && (mem_wd == rs2))
            src2 = mem_wdata;
    end

    // Build the entry that would be captured this cycle.
    always_comb begin
        dec         = '0;
        dec.pc      = pc_i;
        dec.aluop   = opcode;
        dec.funct3  = inst_i[14:12];
        dec.funct7  = inst_i[31:25];
        dec.imm     = XLEN'($signed(imm32));
        dec.wd      = rd;
        dec.wreg    = (is_r || is_i || is_u || is_j) && (rd != '0);
        dec.illegal = !(is_r || is_i || is_s || is_b || is_u || is_j);
        if (reg1_read_o)
            dec.reg1 = src1;
        else if ((opcode == OP_AUIPC) || is_j)
            dec.reg1 = pc_i;
        dec.reg2 = reg2_read_o ? src2 : dec.imm;
    end

    // Stall when a needed source is a load still in EX. Without forwarding,
    // any pending EX/MEM write to a source must drain to the regfile first.
    always_comb begin
        hazard = 1'b0;
        if (ex_wreg && ex_is_load && (ex_wd != '0)) begin
            if ((reg1_read_o && (rs1 == ex_wd)) || (reg2_read_o && (rs2 == ex_wd)))
                hazard = 1'b1;
        end
        if (!FWD_ON) begin
            if (reg1_read_o && (rs1 != '0) &&
                ((ex_wreg && (ex_wd == rs1)) || (mem_wreg && (mem_wd == rs1))))
                hazard = 1'b1;
            if (reg2_read_o && (rs2 != '0) &&
                ((ex_wreg && (ex_wd == rs2)) || (mem_wreg && (mem_wd == rs2))))
                hazard = 1'b1;
        end
        hazard = hazard && in_valid;
    end

    assign in_ready  = (state != TWO) && !hazard && !flush;
    assign capture   = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign consume   = out_valid && out_ready;

    // Head/skid buffer. The head always holds the older entry, and the
    // registers are only written on a handshake, so the outputs stay stable
    // while the consumer stalls. Flush discards both entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (capture) begin
                        head  <= dec;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (capture && consume) begin
                        head <= dec;
                    end else if (capture) begin
                        skid  <= dec;
                        state <= TWO;
                    end else if (consume) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign pc_o        = head.pc;
    assign aluop_o     = head.aluop;
    assign alufunct3_o = head.funct3;
    assign alufunct7_o = head.funct7;
    assign reg1_o      = head.reg1;
    assign reg2_o      = head.reg2;
    assign imm_o       = head.imm;
    assign wd_o        = head.wd;
    assign wreg_o      = head.wreg;
    assign illegal_o   = head.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
// Directed-vector bench for id_stage_pipe. The regfile is stood in for by a
// fixed pattern (rs1 reads 0xA000_0000|addr, rs2 reads 0xB000_0000|addr), so
// expected operand values are hand-computable.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        reg1_read;
    logic [4:0]  reg1_addr;
    logic [31:0] reg1_data;
    logic        reg2_read;
    logic [4:0]  reg2_addr;
    logic [31:0] reg2_data;
    logic        ex_wreg;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata;
    logic        ex_is_load;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_o;
    logic [6:0]  aluop;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] reg1_o;
    logic [31:0] reg2_o;
    logic [31:0] imm_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        illegal_o;

    int vecCount  = 0;
    int failCount = 0;

    id_stage_pipe #(.XLEN(32), .REG_AW(5), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_read_o(reg1_read), .reg1_addr_o(reg1_addr), .reg1_data_i(reg1_data),
        .reg2_read_o(reg2_read), .reg2_addr_o(reg2_addr), .reg2_data_i(reg2_data),
        .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .aluop_o(aluop), .alufunct3_o(funct3), .alufunct7_o(funct7),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o)
    );

    assign reg1_data = 32'hA000_0000 | {27'd0, reg1_addr};
    assign reg2_data = 32'hB000_0000 | {27'd0, reg2_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode vectors streamed with out_ready=1; no forwarding sources active.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        logic        wreg;
        logic        illegal;
        logic [4:0]  wd;
    } vec_t;

    vec_t vecs[9] = '{
        '{32'h123453B7, 32'h400, 32'h0,        32'h12345000, 32'h12345000, 1'b1, 1'b0, 5'd7},
        '{32'h00001297, 32'h404, 32'h404,      32'h00001000, 32'h00001000, 1'b1, 1'b0, 5'd5},
        '{32'hFFDFF0EF, 32'h408, 32'h408,      32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 1'b0, 5'd1},
        '{32'hFE208CE3, 32'h40C, 32'hA0000001, 32'hB0000002, 32'hFFFFFFF8, 1'b0, 1'b0, 5'd25},
        '{32'h0020A423, 32'h410, 32'hA0000001, 32'hB0000002, 32'h00000008, 1'b0, 1'b0, 5'd8},
        '{32'h00000013, 32'h414, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 5'd0},
        '{32'hFFF12303, 32'h418, 32'hA0000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd6},
        '{32'h002081B3, 32'h41C, 32'hA0000001, 32'hB0000002, 32'h0,        1'b1, 1'b0, 5'd3},
        '{32'hFFFFFFFF, 32'h420, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 5'd31}
    };

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = valid;
        pc_i     = pc;
        inst_i   = inst;
    endtask

    // Advance one cycle and land 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0; ex_is_load = 1'b0;
        mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
        applyStimulus(1'b0, 32'h0, 32'h0);
        tick();
        tick();

        // Reset state
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst pc_o", pc_o, 32'd0);
        checkOutput("rst wreg_o", 32'(wreg_o), 32'd0);
        checkOutput("rst illegal_o", 32'(illegal_o), 32'd0);
        checkOutput("rst aluop_o", 32'(aluop), 32'd0);
        checkOutput("rst imm_o", imm_o, 32'd0);
        checkOutput("idle reg1_read", 32'(reg1_read), 32'd0);
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);

        rst = 1'b1;
        tick();

        // addi x1,x0,5
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h100, 32'h00500093);
        #1;
        checkOutput("addi reg1_read", 32'(reg1_read), 32'd1);
        checkOutput("addi reg2_read", 32'(reg2_read), 32'd0);
        checkOutput("addi in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("addi out_valid", 32'(out_valid), 32'd1);
        checkOutput("addi pc_o", pc_o, 32'h100);
        checkOutput("addi reg1_o", reg1_o, 32'd0);
        checkOutput("addi reg2_o", reg2_o, 32'd5);
        checkOutput("addi imm_o", imm_o, 32'd5);
        checkOutput("addi wd_o", 32'(wd_o), 32'd1);
        checkOutput("addi wreg_o", 32'(wreg_o), 32'd1);
        checkOutput("addi aluop_o", 32'(aluop), 32'h13);

        // Forwarding: add x3,x1,x2 with x1 from EX and x2 from MEM
        ex_wreg = 1'b1; ex_wd = 5'd1; ex_wdata = 32'd7;
        mem_wreg = 1'b1; mem_wd = 5'd2; mem_wdata = 32'd9;
        applyStimulus(1'b1, 32'h104, 32'h002081B3);
        tick();
        checkOutput("fwd reg1_o", reg1_o, 32'd7);
        checkOutput("fwd reg2_o", reg2_o, 32'd9);
        checkOutput("fwd wd_o", 32'(wd_o), 32'd3);
        checkOutput("fwd aluop_o", 32'(aluop), 32'h33);

        // EX beats MEM for the same register: add x3,x1,x1
        mem_wd = 5'd1;
        applyStimulus(1'b1, 32'h108, 32'h001081B3);
        tick();
        checkOutput("prio reg1_o", reg1_o, 32'd7);
        checkOutput("prio reg2_o", reg2_o, 32'd7);

        // x0 is never forwarded: add x5,x0,x0 with EX/MEM writing x0
        ex_wd = 5'd0; mem_wd = 5'd0;
        applyStimulus(1'b1, 32'h10C, 32'h000002B3);
        tick();
        checkOutput("x0 reg1_o", reg1_o, 32'd0);
        checkOutput("x0 reg2_o", reg2_o, 32'd0);
        ex_wreg = 1'b0; mem_wreg = 1'b0;

        // Load-use stall on x1
        ex_wreg = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd1; ex_wdata = 32'hDEAD;
        applyStimulus(1'b1, 32'h110, 32'h002081B3);
        #1;
        checkOutput("loaduse in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("loaduse out_valid", 32'(out_valid), 32'd0);
        ex_wreg = 1'b0; ex_is_load = 1'b0;
        #1;
        checkOutput("loaduse released in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("loaduse pc_o", pc_o, 32'h110);
        checkOutput("loaduse reg1_o", reg1_o, 32'hA0000001);
        checkOutput("loaduse reg2_o", reg2_o, 32'hB0000002);
        applyStimulus(1'b0, 32'h0, 32'h0);
        tick();

        // Backpressure fills both entries, then drains in order
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h200, 32'h01100213);
        tick();
        checkOutput("bp1 out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp1 pc_o", pc_o, 32'h200);
        applyStimulus(1'b1, 32'h204, 32'h02200293);
        tick();
        checkOutput("bp2 pc_o", pc_o, 32'h200);
        checkOutput("bp2 in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 32'h208, 32'h03300313);
        tick();
        checkOutput("bp3 pc_o", pc_o, 32'h200);
        checkOutput("bp3 imm_o", imm_o, 32'h11);
        out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("drain1 out_valid", 32'(out_valid), 32'd1);
        checkOutput("drain1 pc_o", pc_o, 32'h204);
        checkOutput("drain1 imm_o", imm_o, 32'h22);
        tick();
        checkOutput("drain2 out_valid", 32'(out_valid), 32'd0);

        // Flush while full, with new input presented in the flush cycle
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h300, 32'h01100213);
        tick();
        applyStimulus(1'b1, 32'h304, 32'h02200293);
        tick();
        flush = 1'b1;
        applyStimulus(1'b1, 32'h308, 32'h03300313);
        #1;
        checkOutput("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("flush out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("postflush in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("postflush out_valid", 32'(out_valid), 32'd0);

        // Decode table: formats, immediates, x0 destination, illegal opcode
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].pc, vecs[i].inst);
            tick();
            checkOutput($sformatf("vec%0d pc_o", i), pc_o, vecs[i].pc);
            checkOutput($sformatf("vec%0d reg1_o", i), reg1_o, vecs[i].reg1);
            checkOutput($sformatf("vec%0d reg2_o", i), reg2_o, vecs[i].reg2);
            checkOutput($sformatf("vec%0d imm_o", i), imm_o, vecs[i].imm);
            checkOutput($sformatf("vec%0d wreg_o", i), 32'(wreg_o), 32'(vecs[i].wreg));
            checkOutput($sformatf("vec%0d illegal_o", i), 32'(illegal_o), 32'(vecs[i].illegal));
            checkOutput($sformatf("vec%0d wd_o", i), 32'(wd_o), 32'(vecs[i].wd));
        end

        // Asynchronous reset mid-stream clears outputs without a clock edge
        applyStimulus(1'b1, 32'h500, 32'h00500093);
        tick();
        checkOutput("prerst out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("async rst pc_o", pc_o, 32'd0);
        checkOutput("async rst wreg_o", 32'(wreg_o), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("postrst out_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
